// File: rtl/sort_pkg.sv
// sort_pkg: definitions shared by the 4-input sort pipeline and the
// sort_merge 2-way merger.
//   WIDTH         - bit width of every number
//   GROUP         - elements per sorted group (fixed at 4)
//   num_t / grp_t - one number / one group of numbers
//   merge_state_t - states of the sort_merge controller
package sort_pkg;

  localparam int WIDTH = 5;
  localparam int GROUP = 4;

  typedef logic [WIDTH-1:0] num_t;
  typedef num_t grp_t [GROUP];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    MERGE  = 2'd2
  } merge_state_t;

endpackage

// File: rtl/merge_sel.sv
// merge_sel: combinational head-of-buffer selection for sort_merge.
// Ports:
//   head_a, head_b - current heads of buffers A and B
//   a_done, b_done - buffer exhausted flags (pointer reached GROUP)
//   sel            - value chosen for output
//   take_a         - 1 when the value comes from buffer A
// Ties select A so that equal values keep their group order.
module merge_sel #(
  parameter int WIDTH = sort_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] head_a,
  input  logic [WIDTH-1:0] head_b,
  input  logic             a_done,
  input  logic             b_done,
  output logic [WIDTH-1:0] sel,
  output logic             take_a
);

  // Choose the larger head, skipping an exhausted buffer.
  always_comb begin
    take_a = 1'b0;
    if (a_done) begin
      take_a = 1'b0;
    end else if (b_done) begin
      take_a = 1'b1;
    end else begin
      take_a = (head_a >= head_b);
    end
    sel = take_a ? head_a : head_b;
  end

endmodule

// File: rtl/sort_merge.sv
// sort_merge: streaming 2-way merger. Accepts two descending 4-element
// groups on consecutive input handshakes, then emits the 8 merged values
// largest first, one per accepted output beat.
// Ports:
//   clk                    - rising-edge clock
//   rst_n                  - synchronous reset, asserted HIGH (name kept
//                            for compatibility with the sort pipeline)
//   in_valid, in_ready     - input group handshake
//   in_number1..in_number4 - input group, expected descending
//   out_valid, out_ready   - output beat handshake
//   out_number, out_last   - merged element, high on the 8th element
//   err                    - sticky input-order error
// Build option: define SORT_MERGE_CHECK_EN to enable the err checker;
// otherwise err is tied low.
module sort_merge
  import sort_pkg::*;
#(
  parameter int WIDTH = sort_pkg::WIDTH,
  parameter int GROUP = sort_pkg::GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_number1,
  input  logic [WIDTH-1:0] in_number2,
  input  logic [WIDTH-1:0] in_number3,
  input  logic [WIDTH-1:0] in_number4,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_number,
  output logic             out_last,
  input  logic             out_ready,
  output logic             err
);

  merge_state_t     state_q, state_d;
  logic [WIDTH-1:0] buf_a_q [GROUP];
  logic [WIDTH-1:0] buf_a_d [GROUP];
  logic [WIDTH-1:0] buf_b_q [GROUP];
  logic [WIDTH-1:0] buf_b_d [GROUP];
  logic [2:0]       ia_q, ia_d;
  logic [2:0]       ib_q, ib_d;

  logic             a_done;
  logic             b_done;
  logic             take_a;
  logic [WIDTH-1:0] sel_num;
  logic             in_accept;
  logic             out_fire;
  logic [3:0]       ptr_sum;

  assign a_done   = (ia_q == 3'd4);
  assign b_done   = (ib_q == 3'd4);
  assign ptr_sum  = {1'b0, ia_q} + {1'b0, ib_q};

  merge_sel #(.WIDTH(WIDTH)) u_merge_sel (
    .head_a (buf_a_q[ia_q[1:0]]),
    .head_b (buf_b_q[ib_q[1:0]]),
    .a_done (a_done),
    .b_done (b_done),
    .sel    (sel_num),
    .take_a (take_a)
  );

  // Handshake outputs decoded from the current state and pointers.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_number = '0;
    out_last   = 1'b0;
    case (state_q)
      IDLE, LOAD_B: begin
        in_ready = 1'b1;
      end
      MERGE: begin
        out_valid  = 1'b1;
        out_number = sel_num;
        out_last   = (ptr_sum == 4'd7);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign in_accept = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Next-state, buffer capture and pointer advance.
  always_comb begin
    state_d = state_q;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    ia_d    = ia_q;
    ib_d    = ib_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_a_d[0] = in_number1;
          buf_a_d[1] = in_number2;
          buf_a_d[2] = in_number3;
          buf_a_d[3] = in_number4;
          state_d    = LOAD_B;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          buf_b_d[0] = in_number1;
          buf_b_d[1] = in_number2;
          buf_b_d[2] = in_number3;
          buf_b_d[3] = in_number4;
          ia_d       = 3'd0;
          ib_d       = 3'd0;
          state_d    = MERGE;
        end else begin
          state_d = LOAD_B;
        end
      end
      MERGE: begin
        if (out_fire) begin
          if (take_a) begin
            ia_d = ia_q + 3'd1;
          end else begin
            ib_d = ib_q + 3'd1;
          end
          state_d = out_last ? IDLE : MERGE;
        end else begin
          state_d = MERGE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, buffer and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      ia_q    <= 3'd0;
      ib_q    <= 3'd0;
      for (int i = 0; i < GROUP; i++) begin
        buf_a_q[i] <= '0;
        buf_b_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ia_q    <= ia_d;
      ib_q    <= ib_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
    end
  end

`ifdef SORT_MERGE_CHECK_EN
  logic err_q, err_d;
  logic not_desc;

  // Sticky error: unsorted accepted group, or a group offered while busy.
  always_comb begin
    not_desc = (in_number1 < in_number2) || (in_number2 < in_number3) ||
               (in_number3 < in_number4);
    err_d    = err_q;
    if ((in_accept && not_desc) || (in_valid && !in_ready)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_merge.sv
// tb_sort_merge: directed self-checking bench for sort_merge. Inputs are
// driven and outputs checked on the falling clock edge.
module tb_sort_merge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] in_number1, in_number2, in_number3, in_number4;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_number;
  logic       out_last;
  logic       out_ready;
  logic       err;

  int errors = 0;
  int checks = 0;

`ifdef SORT_MERGE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  sort_merge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_number1 (in_number1),
    .in_number2 (in_number2),
    .in_number3 (in_number3),
    .in_number4 (in_number4),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_number (out_number),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle: from one falling edge to the next.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one group for a single rising edge.
  task automatic send(input logic [19:0] g);
    in_valid   = 1'b1;
    in_number1 = g[19:15];
    in_number2 = g[14:10];
    in_number3 = g[9:5];
    in_number4 = g[4:0];
    step();
    in_valid = 1'b0;
  endtask

  // Check beats [first..last_i] of an expected sequence; stall[i] inserts
  // one out_ready=0 cycle before beat i and checks the outputs are held.
  task automatic drain(input string tag, input logic [39:0] exp,
                       input logic [7:0] stall, input int first, input int last_i);
    logic [4:0] e;
    for (int i = first; i <= last_i; i++) begin
      e = exp[39-5*i -: 5];
      if (stall[i]) begin
        out_ready = 1'b0;
        step();
        check({tag, "_hold_num"}, out_number, e);
        check({tag, "_hold_last"}, out_last, (i == 7) ? 1 : 0);
        out_ready = 1'b1;
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_num"}, out_number, e);
      check({tag, "_last"}, out_last, (i == 7) ? 1 : 0);
      check({tag, "_in_ready_busy"}, in_ready, 0);
      step();
    end
    if (last_i == 7) begin
      check({tag, "_done_valid"}, out_valid, 0);
      check({tag, "_done_in_ready"}, in_ready, 1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
  endtask

  initial begin
    in_valid   = 1'b0;
    in_number1 = 5'd0;
    in_number2 = 5'd0;
    in_number3 = 5'd0;
    in_number4 = 5'd0;
    out_ready  = 1'b1;
    rst_n      = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state.
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_number", out_number, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);

    // Basic interleaved merge with a tie.
    send({5'd20, 5'd15, 5'd9, 5'd3});
    check("loadb_in_ready", in_ready, 1);
    check("loadb_out_valid", out_valid, 0);
    send({5'd18, 5'd15, 5'd4, 5'd1});
    drain("t1", {5'd20, 5'd18, 5'd15, 5'd15, 5'd9, 5'd4, 5'd3, 5'd1}, 8'h00, 0, 7);

    // A entirely larger, then swapped.
    send({5'd31, 5'd30, 5'd29, 5'd28});
    send({5'd3, 5'd2, 5'd1, 5'd0});
    drain("t2a", {5'd31, 5'd30, 5'd29, 5'd28, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h00, 0, 7);
    send({5'd3, 5'd2, 5'd1, 5'd0});
    send({5'd31, 5'd30, 5'd29, 5'd28});
    drain("t2b", {5'd31, 5'd30, 5'd29, 5'd28, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h00, 0, 7);

    // Backpressure on the first case.
    send({5'd20, 5'd15, 5'd9, 5'd3});
    send({5'd18, 5'd15, 5'd4, 5'd1});
    drain("t3", {5'd20, 5'd18, 5'd15, 5'd15, 5'd9, 5'd4, 5'd3, 5'd1}, 8'b1001_0110, 0, 7);
    check("t3_err", err, 0);

    // Reset mid-merge after 3 beats.
    send({5'd20, 5'd15, 5'd9, 5'd3});
    send({5'd18, 5'd15, 5'd4, 5'd1});
    drain("t4pre", {5'd20, 5'd18, 5'd15, 5'd15, 5'd9, 5'd4, 5'd3, 5'd1}, 8'h00, 0, 2);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    check("t4_rst_valid", out_valid, 0);
    check("t4_rst_in_ready", in_ready, 1);
    step();
    check("t4_idle_valid", out_valid, 0);
    send({5'd5, 5'd5, 5'd5, 5'd5});
    send({5'd5, 5'd5, 5'd5, 5'd5});
    drain("t4", {8{5'd5}}, 8'h00, 0, 7);

    // Group offered during MERGE is dropped.
    send({5'd31, 5'd30, 5'd29, 5'd28});
    send({5'd3, 5'd2, 5'd1, 5'd0});
    drain("t5pre", {5'd31, 5'd30, 5'd29, 5'd28, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h00, 0, 1);
    check("t5_err_before", err, 0);
    out_ready = 1'b0;
    send({5'd1, 5'd2, 5'd3, 5'd4});
    out_ready = 1'b1;
    check("t5_drop_num", out_number, 29);
    check("t5_drop_valid", out_valid, 1);
    check("t5_drop_err", err, CHK);
    drain("t5", {5'd31, 5'd30, 5'd29, 5'd28, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h00, 2, 7);
    check("t5_err_sticky", err, CHK);

    // Unsorted group accepted as A.
    do_reset();
    check("t6_err_cleared", err, 0);
    send({5'd3, 5'd7, 5'd1, 5'd0});
    check("t6_err_set", err, CHK);
    send({5'd5, 5'd4, 5'd3, 5'd2});
    drain("t6", {5'd5, 5'd4, 5'd3, 5'd7, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h00, 0, 7);
    check("t6_err_sticky", err, CHK);
    do_reset();
    check("t6_err_reset", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
